// File: rtl/div_reconstruct_pkg.sv
// Shared types and constants for the dividend reconstructor (q*d + r).
// Holds the FSM state encoding, the default operand width and the bit-counter width.
package div_reconstruct_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/div_reconstruct_shift_add_mul.sv
// Purpose: unsigned one-bit-per-cycle shift-add multiplier, 2*WIDTH-bit product.
// Latency: exactly WIDTH cycles after start; done flags the final step.
// Backpressure: none; the product holds once the counter reaches zero.
module shift_add_mul
    import div_reconstruct_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, multiplicand};
            mplier_q <= multiplier;
            acc_q    <= '0;
            cnt_q    <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            // No early exit on zero operands: the step count is fixed.
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CNT_W'(1);
        end
    end

    assign product = acc_q;
    assign done    = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/div_reconstruct.sv
// Purpose: dividend = quotient*divisor + remainder over ready/valid streams (DIV_RECONSTRUCT_CHECK_EN adds checks).
// Latency: WIDTH+1 cycles accept-to-o_valid; one transaction per WIDTH+3 cycles.
// Backpressure: result held in DONE until o_ready; i_ready only in IDLE.
module div_reconstruct
    import div_reconstruct_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_payload_quotient,
    input  logic [WIDTH-1:0] i_payload_divisor,
    input  logic [WIDTH-1:0] i_payload_remainder,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_payload_dividend,
    output logic             o_payload_overflow,
    output logic             o_payload_check_err,
    output logic             o_payload_divzero
);

    state_t             state;
    logic               accept;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   rem_q;
    logic               chk_q;
    logic               dz_q;
    logic               chk_in;
    logic               dz_in;
    logic [2*WIDTH:0]   sum;

    assign i_ready = (state == IDLE);
    assign accept  = i_valid && i_ready;

`ifdef DIV_RECONSTRUCT_CHECK_EN
    assign chk_in = (i_payload_divisor != '0) && (i_payload_remainder >= i_payload_divisor);
    assign dz_in  = (i_payload_divisor == '0) && (&i_payload_quotient) && (&i_payload_remainder);
`else
    assign chk_in = 1'b0;
    assign dz_in  = 1'b0;
`endif

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (accept),
        .multiplicand (i_payload_quotient),
        .multiplier   (i_payload_divisor),
        .product      (product),
        .done         (mul_done)
    );

    // Full-width sum so the range test sees every carry.
    always_comb begin
        sum = '0;
        sum = {1'b0, product} + {{(WIDTH+1){1'b0}}, rem_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            rem_q               <= '0;
            chk_q               <= 1'b0;
            dz_q                <= 1'b0;
            o_valid             <= 1'b0;
            o_payload_dividend  <= '0;
            o_payload_overflow  <= 1'b0;
            o_payload_check_err <= 1'b0;
            o_payload_divzero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        rem_q <= i_payload_remainder;
                        chk_q <= chk_in;
                        dz_q  <= dz_in;
                        state <= MUL;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state <= ADD;
                    end
                end
                ADD: begin
                    // The divide-by-zero marker reports a clean zero result.
                    o_payload_dividend  <= dz_q ? '0 : sum[WIDTH-1:0];
                    o_payload_overflow  <= dz_q ? 1'b0 : (|sum[2*WIDTH:WIDTH]);
                    o_payload_check_err <= chk_q;
                    o_payload_divzero   <= dz_q;
                    o_valid             <= 1'b1;
                    state               <= DONE;
                end
                DONE: begin
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_reconstruct.sv
// Bench for div_reconstruct: scoreboard of expected {dividend, overflow, check_err, divzero}.
module tb_div_reconstruct;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_valid = 1'b0;
    logic         i_ready;
    logic [W-1:0] i_payload_quotient = '0;
    logic [W-1:0] i_payload_divisor = '0;
    logic [W-1:0] i_payload_remainder = '0;
    logic         o_valid;
    logic         o_ready = 1'b1;
    logic [W-1:0] o_payload_dividend;
    logic         o_payload_overflow;
    logic         o_payload_check_err;
    logic         o_payload_divzero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic [W+2:0] sb[$];

    div_reconstruct #(.WIDTH(W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_valid             (i_valid),
        .i_ready             (i_ready),
        .i_payload_quotient  (i_payload_quotient),
        .i_payload_divisor   (i_payload_divisor),
        .i_payload_remainder (i_payload_remainder),
        .o_valid             (o_valid),
        .o_ready             (o_ready),
        .o_payload_dividend  (o_payload_dividend),
        .o_payload_overflow  (o_payload_overflow),
        .o_payload_check_err (o_payload_check_err),
        .o_payload_divzero   (o_payload_divzero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W+2:0] model(input logic [W-1:0] q, input logic [W-1:0] d,
                                           input logic [W-1:0] r);
        logic [2*W:0] qe, de, re, s;
        logic chk, dz;
        qe = 0; de = 0; re = 0;
        qe[W-1:0] = q;
        de[W-1:0] = d;
        re[W-1:0] = r;
        s = qe * de + re;
        chk = 1'b0;
        dz = 1'b0;
`ifdef DIV_RECONSTRUCT_CHECK_EN
        chk = (d != 0) && (r >= d);
        dz = (d == 0) && (q == {W{1'b1}}) && (r == {W{1'b1}});
        if (dz) s = '0;
`endif
        return {s[W-1:0], |s[2*W:W], chk, dz};
    endfunction

    function automatic logic [W+2:0] observed();
        return {o_payload_dividend, o_payload_overflow, o_payload_check_err, o_payload_divzero};
    endfunction

    // Presents one operand set at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                        input bit push);
        int n;
        @(negedge clk);
        n = 0;
        while (i_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        i_valid = 1'b1;
        i_payload_quotient = q;
        i_payload_divisor = d;
        i_payload_remainder = r;
        if (push) sb.push_back(model(q, d, r));
        @(negedge clk);
        i_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    // Waits (bounded) for o_valid; reports latency and whether i_ready stayed low while busy.
    task automatic wait_valid(input int max, output int lat, output bit ok, output bit rdy_low);
        ok = 1'b0;
        rdy_low = 1'b1;
        for (int i = 0; i < max; i++) begin
            if (o_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (i_ready !== 1'b0) rdy_low = 1'b0;
            @(negedge clk);
        end
        lat = cyc - acc_cyc;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: i_ready=%b o_valid=%b, required 1/0", i_ready, o_valid);
        end
        checks++;
        if (observed() !== '0) begin
            errors++;
            $display("FAIL reset_payload: got %h, required 0", observed());
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat; bit ok, rl; logic [W+2:0] e;
        o_ready = 1'b1;
        send(3, 5, 2, 1'b1);
        wait_valid(100, lat, ok, rl);
        checks++;
        if (!ok || lat != LAT) begin
            errors++;
            $display("FAIL basic_latency: o_valid=%b after %0d cycles, required %0d", ok, lat, LAT);
        end
        checks++;
        if (!rl) begin
            errors++;
            $display("FAIL basic_iready: i_ready rose while busy, required low");
        end
        e = sb.pop_front();
        checks++;
        if (observed() !== e) begin
            errors++;
            $display("FAIL basic_result: got %h, required %h", observed(), e);
        end
        @(negedge clk);
        checks++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: i_ready=%b o_valid=%b, required 1/0", i_ready, o_valid);
        end
    endtask

    task automatic test_overflow();
        int lat; bit ok, rl; logic [W+2:0] e;
        send(32'hFFFF_FFFF, 2, 1, 1'b1);
        wait_valid(100, lat, ok, rl);
        e = sb.pop_front();
        checks++;
        if (!ok || observed() !== e) begin
            errors++;
            $display("FAIL overflow_result: valid=%b got %h, required %h", ok, observed(), e);
        end
        @(negedge clk);
    endtask

    task automatic test_check_flags();
        int lat; bit ok, rl; logic [W+2:0] e;
        logic [W-1:0] qs[3] = '{32'd1, 32'hFFFF_FFFF, 32'd0};
        logic [W-1:0] ds[3] = '{32'd5, 32'd0, 32'd0};
        logic [W-1:0] rs[3] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        for (int k = 0; k < 3; k++) begin
            send(qs[k], ds[k], rs[k], 1'b1);
            wait_valid(100, lat, ok, rl);
            e = sb.pop_front();
            checks++;
            if (!ok || lat != LAT || observed() !== e) begin
                errors++;
                $display("FAIL check_flags[%0d]: valid=%b lat=%0d got %h, required lat %0d %h",
                         k, ok, lat, observed(), LAT, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int lat; bit ok, rl, stable; logic [W+2:0] e;
        o_ready = 1'b0;
        send(7, 6, 0, 1'b1);
        wait_valid(100, lat, ok, rl);
        e = sb.pop_front();
        checks++;
        if (!ok || observed() !== e) begin
            errors++;
            $display("FAIL bp_result: valid=%b got %h, required %h", ok, observed(), e);
        end
        stable = 1'b1;
        i_valid = 1'b1;
        i_payload_quotient = 9;
        i_payload_divisor = 9;
        i_payload_remainder = 9;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_valid !== 1'b1 || i_ready !== 1'b0 || observed() !== e) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL bp_hold: payload/handshake moved during hold, now %h valid=%b rdy=%b, required %h 1 0",
                     observed(), o_valid, i_ready, e);
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: o_valid=%b i_ready=%b, required 0/1", o_valid, i_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit ok, rl, quiet; logic [W+2:0] e;
        send(1, 1, 1, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (i_ready !== 1'b1 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: i_ready=%b o_valid=%b, required 1/0", i_ready, o_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_valid !== 1'b0 || i_ready !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL midreset_quiet: abandoned transaction produced activity, o_valid=%b", o_valid);
        end
        send(2, 2, 0, 1'b1);
        wait_valid(100, lat, ok, rl);
        e = sb.pop_front();
        checks++;
        if (!ok || lat != LAT || observed() !== e) begin
            errors++;
            $display("FAIL midreset_next: valid=%b lat=%0d got %h, required %h", ok, lat, observed(), e);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qs[4] = '{32'd100, 32'd0, 32'hFFFF_FFFF, 32'd12345};
        logic [W-1:0] ds[4] = '{32'd3, 32'd0, 32'hFFFF_FFFF, 32'd678};
        logic [W-1:0] rs[4] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd9};
        int sent, got, last_out, budget;
        bit pending;
        logic [W+2:0] e;
        o_ready = 1'b1;
        @(negedge clk);
        sent = 0; got = 0; last_out = 0; budget = 0; pending = 1'b0;
        i_valid = 1'b1;
        i_payload_quotient = qs[0];
        i_payload_divisor = ds[0];
        i_payload_remainder = rs[0];
        while (got < 4 && budget < 4 * (W + 3) + 60) begin
            if (pending) begin
                sent++;
                pending = 1'b0;
                if (sent < 4) begin
                    i_payload_quotient = qs[sent];
                    i_payload_divisor = ds[sent];
                    i_payload_remainder = rs[sent];
                end else begin
                    i_valid = 1'b0;
                end
            end
            if (o_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: unexpected output %h", got, observed());
                end else begin
                    e = sb.pop_front();
                    if (observed() !== e) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got %h, required %h", got, observed(), e);
                    end
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - last_out != W + 3) begin
                        errors++;
                        $display("FAIL b2b_spacing[%0d]: %0d cycles, required %0d",
                                 got, cyc - last_out, W + 3);
                    end
                end
                last_out = cyc;
                got++;
            end
            if (i_valid === 1'b1 && i_ready === 1'b1) begin
                sb.push_back(model(i_payload_quotient, i_payload_divisor, i_payload_remainder));
                pending = 1'b1;
            end
            @(negedge clk);
            budget++;
        end
        i_valid = 1'b0;
        checks++;
        if (got != 4) begin
            errors++;
            $display("FAIL b2b_count: %0d results, required 4", got);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_check_flags();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
